mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (if_*)
//   and a data-memory requester (dm_*). A pending request is granted
//   combinationally while idle. Address, write enable and write data are
//   registered at the grant edge. The port then stays busy until mem_ready
//   arrives or the timeout expires. Completion is signalled by a one-cycle
//   *_valid pulse to the owner. On a timeout, err pulses alongside that
//   *_valid.
//
// Parameters
//   AW             address width
//   DW             data width
//   TIMEOUT_CYCLES busy cycles allowed without mem_ready (>= 1)
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req, if_addr                 fetch request and address
//   if_gnt, if_valid, if_rdata      fetch grant, completion, instruction word
//   dm_req, dm_we, dm_addr, dm_wdata  data request, write enable, addr, data
//   dm_gnt, dm_valid, dm_rdata      data grant, completion, load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ready shared memory port
//   stall                           processor freeze
//   err                             timeout pulse (together with *_valid)
//
// Configuration
//   MEM_ARB_RR_EN  when defined, ties are broken round-robin (dm wins the
//                  first tie after reset); otherwise dm always beats fetch.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic          memWe_q, memWe_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic [DW-1:0] ifRdata_q, ifRdata_d;
  logic [DW-1:0] dmRdata_q, dmRdata_d;
  logic          ifValid_q, ifValid_d;
  logic          dmValid_q, dmValid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grantIf, grantDm;

`ifdef MEM_ARB_RR_EN
  // Remembers who won the last grant; reset value "fetch" lets dm win first.
  logic          lastDm_q, lastDm_d;
`endif

  // Arbitration: grants are only issued while idle, at most one at a time.
  always_comb begin
    grantIf = 1'b0;
    grantDm = 1'b0;
    if (state_q == IDLE) begin
`ifdef MEM_ARB_RR_EN
      if (dm_req && if_req) begin
        grantDm = !lastDm_q;
        grantIf = lastDm_q;
      end else begin
        grantDm = dm_req;
        grantIf = if_req;
      end
`else
      grantDm = dm_req;
      grantIf = if_req && !dm_req;
`endif
    end
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    lastDm_d = lastDm_q;
    if (grantDm) lastDm_d = 1'b1;
    else if (grantIf) lastDm_d = 1'b0;
  end
`endif

  // Next-state logic. Completion (mem_ready) takes precedence over the
  // timeout, so a response arriving in the last allowed cycle still counts.
  always_comb begin
    state_d    = state_q;
    memAddr_d  = memAddr_q;
    memWe_d    = memWe_q;
    memWdata_d = memWdata_q;
    ifRdata_d  = ifRdata_q;
    dmRdata_d  = dmRdata_q;
    ifValid_d  = 1'b0;
    dmValid_d  = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grantDm) begin
          state_d    = BUSY_DM;
          memAddr_d  = dm_addr;
          memWe_d    = dm_we;
          memWdata_d = dm_wdata;
        end else if (grantIf) begin
          state_d    = BUSY_IF;
          memAddr_d  = if_addr;
          memWe_d    = 1'b0;
          memWdata_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == BUSY_IF) begin
            ifValid_d = 1'b1;
            ifRdata_d = mem_rdata;
          end else begin
            dmValid_d = 1'b1;
            dmRdata_d = memWe_q ? '0 : mem_rdata;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (state_q == BUSY_IF) begin
            ifValid_d = 1'b1;
            ifRdata_d = '0;
          end else begin
            dmValid_d = 1'b1;
            dmRdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memAddr_q  <= '0;
      memWe_q    <= 1'b0;
      memWdata_q <= '0;
      ifRdata_q  <= '0;
      dmRdata_q  <= '0;
      ifValid_q  <= 1'b0;
      dmValid_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
      lastDm_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      memAddr_q  <= memAddr_d;
      memWe_q    <= memWe_d;
      memWdata_q <= memWdata_d;
      ifRdata_q  <= ifRdata_d;
      dmRdata_q  <= dmRdata_d;
      ifValid_q  <= ifValid_d;
      dmValid_q  <= dmValid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef MEM_ARB_RR_EN
      lastDm_q   <= lastDm_d;
`endif
    end
  end

  // mem_req/mem_we derive from state so an async reset drops them at once.
  assign if_gnt    = grantIf;
  assign dm_gnt    = grantDm;
  assign if_valid  = ifValid_q;
  assign dm_valid  = dmValid_q;
  assign if_rdata  = ifRdata_q;
  assign dm_rdata  = dmRdata_q;
  assign err       = err_q;
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == BUSY_DM) && memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign stall     = ((if_req || dm_req) || (state_q != IDLE)) && !(ifValid_q || dmValid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES = 4).
//   A table of single transactions is replayed through applyStimulus; a
//   completion monitor pops expected owner/rdata/err from a scoreboard queue
//   on every *_valid pulse. Hand sequences cover reset, tie-breaking,
//   back-to-back grants and reset abort. Honours MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          stall, err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isDm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic        isDm;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[7];
  logic expOrder[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic isDm, input logic [31:0] rdata, input logic e);
    exp_t x;
    x.isDm  = isDm;
    x.rdata = rdata;
    x.err   = e;
    sbQ.push_back(x);
  endtask

  // Completion monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_valid || dm_valid) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: if_valid=%0b dm_valid=%0b expected no completion",
                 if_valid, dm_valid);
      end else begin
        e = sbQ.pop_front();
        checkOutput("if_valid_owner", 32'(if_valid), 32'(!e.isDm));
        checkOutput("dm_valid_owner", 32'(dm_valid), 32'(e.isDm));
        checkOutput("rdata", e.isDm ? dm_rdata : if_rdata, e.rdata);
        checkOutput("err_with_valid", 32'(err), 32'(e.err));
      end
    end else if (err) begin
      checkOutput("err_without_valid", 32'(err), 32'd0);
    end
  end

  // One isolated transaction: request, wait (bounded) for grant, play memory.
  task automatic applyStimulus(input vec_t v);
    bit got;
    @(posedge clk); #1;
    if (v.isDm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v.isDm ? dm_gnt : if_gnt) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("grant_seen", 32'(got), 32'd1);
    if (!got) begin
      #1; if_req = 1'b0; dm_req = 1'b0;
      return;
    end
    pushExp(v.isDm, v.expRdata, v.expErr);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    for (int k = 0; k < TO; k++) begin
      mem_ready = (k == v.delay);
      mem_rdata = v.rdata;
      @(negedge clk);
      checkOutput("mem_req_busy", 32'(mem_req), 32'd1);
      if (k == 0) begin
        checkOutput("mem_addr", mem_addr, v.addr);
        checkOutput("mem_we", 32'(mem_we), 32'(v.isDm && v.we));
        checkOutput("stall_busy", 32'(stall), 32'd1);
        if (v.isDm && v.we) checkOutput("mem_wdata", mem_wdata, v.wdata);
      end
      @(posedge clk); #1;
      if (k == v.delay) break;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("valid_latency", 32'(v.isDm ? dm_valid : if_valid), 32'd1);
    checkOutput("mem_req_after", 32'(mem_req), 32'd0);
    checkOutput("stall_at_valid", 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            isDm  we    addr          wdata         rdata         dly expRdata      expErr
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0050_0093, 0, 32'h0050_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,        32'h1234_5678, 2, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,        32'h5555_5555, 4, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_2008, 32'h0BAD_F00D, 32'h6666_6666, 4, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'hA5A5_A5A5, 3, 32'hA5A5_A5A5, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_200C, 32'h0,        32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0};
`ifdef MEM_ARB_RR_EN
    expOrder = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    expOrder = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset values.
    #12;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_valids", 32'({if_valid, dm_valid, err}), 32'd0);
    checkOutput("rst_gnts", 32'({if_gnt, dm_gnt}), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_dm_rdata", dm_rdata, 32'd0);

    // Both requesters held for four grants, starting the cycle reset lifts.
    @(negedge clk);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    for (int g = 0; g < 4; g++) begin
      checkOutput("order_dm_gnt", 32'(dm_gnt), 32'(expOrder[g]));
      checkOutput("order_if_gnt", 32'(if_gnt), 32'(!expOrder[g]));
      if (g == 0) checkOutput("stall_pending", 32'(stall), 32'd1);
      pushExp(expOrder[g], 32'h1111_1111, 1'b0);
      @(negedge clk);
      checkOutput("busy_no_gnt", 32'({if_gnt, dm_gnt}), 32'd0);
      checkOutput("busy_addr", mem_addr, expOrder[g] ? 32'h500 : 32'h400);
      if (g == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;

    // Simultaneous write + fetch: dm first, fetch granted alongside dm_valid.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    checkOutput("tie_dm_gnt", 32'(dm_gnt), 32'd1);
    checkOutput("tie_if_gnt", 32'(if_gnt), 32'd0);
    pushExp(1'b1, 32'h0, 1'b0);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_addr", mem_addr, 32'h2000);
    checkOutput("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("wait_if_no_gnt", 32'(if_gnt), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_dm_valid", 32'(dm_valid), 32'd1);
    checkOutput("b2b_if_gnt", 32'(if_gnt), 32'd1);
    pushExp(1'b0, 32'h7777_7777, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
    checkOutput("fetch_mem_addr", mem_addr, 32'h600);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("fetch_valid", 32'(if_valid), 32'd1);

    // Table of single transactions, including ready-on-last-cycle and timeouts.
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Read data holds between pulses.
    repeat (3) @(negedge clk);
    checkOutput("hold_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    checkOutput("hold_if_rdata", if_rdata, 32'hA5A5_A5A5);

    // Reset during BUSY_DM, then a late mem_ready must be ignored.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    @(negedge clk);
    checkOutput("abort_dm_gnt", 32'(dm_gnt), 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async_mem_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_idle_mem_req", 32'(mem_req), 32'd0);
      checkOutput("abort_no_dm_valid", 32'(dm_valid), 32'd0);
      checkOutput("abort_stall", 32'(stall), 32'd0);
    end
    mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
